// File: rtl/regbank_pkg.sv
// regbank_pkg: shared types and helpers for register_bank_pc.
// FSM state encoding and per-index reset value lookup.
package regbank_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Reset value of register idx; only the top index (PC) is non-zero.
   function automatic logic [63:0] reg_reset_value(
      input int unsigned idx,
      input int unsigned depth,
      input logic [63:0] pc_reset
   );
      if (idx == depth - 1) begin
         return pc_reset;
      end
      return '0;
   endfunction

endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with clear > load > increment priority.
// Increment wraps modulo 2^WIDTH.
module pc_register
   import regbank_pkg::*;
#(
   parameter int unsigned       WIDTH     = 16,
   parameter int unsigned       PC_STEP   = 1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             incr,
   output logic [WIDTH-1:0] pc
);

   localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

   // PC update: reset, then clear walk, then explicit load, then step.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc <= RESET_VAL;
      end else if (clear) begin
         pc <= RESET_VAL;
      end else if (load) begin
         pc <= load_data;
      end else if (incr) begin
         pc <= pc + STEP;
      end
   end

endmodule

// File: rtl/register_bank_pc.sv
// register_bank_pc: 2R/1W register bank, PC at top index, clear walker.
// Optional macro BANK_BYPASS_EN forwards write_data to same-cycle reads.
module register_bank_pc
   import regbank_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned PC_STEP  = 1,
   parameter int unsigned PC_RESET = 0,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [AW-1:0]    read1_addr,
   input  logic [AW-1:0]    read2_addr,
   output logic [WIDTH-1:0] read1_data,
   output logic [WIDTH-1:0] read2_data,
   input  logic [AW-1:0]    write_addr,
   input  logic [WIDTH-1:0] write_data,
   input  logic             reg_write,
   input  logic             incr_pc,
   input  logic             clear_req,
   output logic [WIDTH-1:0] pc_out,
   output logic             busy
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
   localparam logic [63:0]   PC_RV    =
      reg_reset_value(DEPTH - 1, DEPTH, 64'(PC_RESET));
   localparam logic [WIDTH-1:0] PC_RV_W = PC_RV[WIDTH-1:0];

   state_t           state_q;
   state_t           state_d;
   logic [AW-1:0]    idx_q;
   logic [AW-1:0]    idx_d;
   logic             idle_act;
   logic             wr_en;
   logic             pc_load;
   logic             pc_incr;
   logic             pc_clear;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] bank [DEPTH];

   // A clear request in IDLE wins over writes and increments that cycle.
   assign idle_act = (state_q == IDLE) && !clear_req;
   assign wr_en    = idle_act && reg_write;
   assign pc_load  = wr_en && (write_addr == LAST_IDX);
   assign pc_incr  = idle_act && incr_pc;
   assign pc_clear = busy && (idx_q == LAST_IDX);

   // Walker state and index register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Walker next state: one register cleared per CLEAR cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            busy  = 1'b1;
            idx_d = idx_q + AW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   for (genvar i = 0; i < int'(DEPTH) - 1; i++) begin : g_gpr
      localparam logic [63:0] RV =
         reg_reset_value(i, DEPTH, 64'(PC_RESET));
      logic             q;
      logic [WIDTH-1:0] val;
      logic             wr_hit;
      logic             clr_hit;

      assign wr_hit  = wr_en && (write_addr == AW'(i));
      assign clr_hit = busy && (idx_q == AW'(i));
      assign q       = 1'b0;

      // General register: reset, walker clear, then write.
      always_ff @(posedge clock) begin
         if (!reset_n) begin
            val <= RV[WIDTH-1:0];
         end else if (clr_hit) begin
            val <= RV[WIDTH-1:0];
         end else if (wr_hit) begin
            val <= write_data;
         end
      end

      assign bank[i] = val | {WIDTH{q}};
   end

   pc_register #(
      .WIDTH     (WIDTH),
      .PC_STEP   (PC_STEP),
      .RESET_VAL (PC_RV_W)
   ) u_pc (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (pc_clear),
      .load      (pc_load),
      .load_data (write_data),
      .incr      (pc_incr),
      .pc        (pc_q)
   );

   assign bank[DEPTH-1] = pc_q;
   assign pc_out        = pc_q;

`ifdef BANK_BYPASS_EN
   logic byp;
   assign byp = reg_write && !busy;

   // Read ports with same-cycle forwarding of the pending write.
   always_comb begin
      read1_data = bank[read1_addr];
      read2_data = bank[read2_addr];
      if (byp && (read1_addr == write_addr)) begin
         read1_data = write_data;
      end
      if (byp && (read2_addr == write_addr)) begin
         read2_data = write_data;
      end
   end
`else
   // Read ports return stored contents only.
   always_comb begin
      read1_data = bank[read1_addr];
      read2_data = bank[read2_addr];
   end
`endif

endmodule

// File: tb/tb_register_bank_pc.sv
// tb_register_bank_pc: randomized and directed checks of register_bank_pc.
// Reference model is an array plus a walk counter.
module tb_register_bank_pc;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [2:0]  read1_addr;
   logic [2:0]  read2_addr;
   logic [15:0] read1_data;
   logic [15:0] read2_data;
   logic [2:0]  write_addr;
   logic [15:0] write_data;
   logic        reg_write;
   logic        incr_pc;
   logic        clear_req;
   logic [15:0] pc_out;
   logic        busy;

   int vec = 0;
   int err = 0;

   logic [15:0] m [8];
   int          walk = -1;

   always #5 clock = ~clock;

   register_bank_pc #(
      .WIDTH    (16),
      .DEPTH    (8),
      .PC_STEP  (1),
      .PC_RESET (0)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .read1_addr (read1_addr),
      .read2_addr (read2_addr),
      .read1_data (read1_data),
      .read2_data (read2_data),
      .write_addr (write_addr),
      .write_data (write_data),
      .reg_write  (reg_write),
      .incr_pc    (incr_pc),
      .clear_req  (clear_req),
      .pc_out     (pc_out),
      .busy       (busy)
   );

   function automatic logic exp_busy();
      return walk >= 0;
   endfunction

   function automatic logic [15:0] exp_rd(input logic [2:0] a);
`ifdef BANK_BYPASS_EN
      if (reg_write && walk < 0 && a == write_addr) return write_data;
`endif
      return m[a];
   endfunction

   task automatic tick();
      @(posedge clock);
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) m[i] = 16'h0000;
         walk = -1;
      end else if (walk >= 0) begin
         m[walk] = 16'h0000;
         walk = (walk == 7) ? -1 : walk + 1;
      end else if (clear_req) begin
         walk = 0;
      end else begin
         if (reg_write) m[write_addr] = write_data;
         if (incr_pc && !(reg_write && write_addr == 3'd7))
            m[7] = m[7] + 16'd1;
      end
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      reg_write  = 1'b0;
      incr_pc    = 1'b0;
      clear_req  = 1'b0;
      write_addr = 3'd0;
      write_data = 16'h0000;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         read1_addr = 3'(i);
         read2_addr = 3'(7 - i);
         #1;
         vec++;
         if (read1_data !== 16'h0000) begin
            err++;
            $display("FAIL reset_rd1[%0d] got %h want 0000", i, read1_data);
         end
         vec++;
         if (read2_data !== 16'h0000) begin
            err++;
            $display("FAIL reset_rd2[%0d] got %h want 0000", 7 - i, read2_data);
         end
      end
      vec++;
      if (pc_out !== 16'h0000) begin
         err++;
         $display("FAIL reset_pc got %h want 0000", pc_out);
      end
      vec++;
      if (busy !== 1'b0) begin
         err++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
   endtask

   task automatic test_same_cycle_write();
      logic [15:0] want;
`ifdef BANK_BYPASS_EN
      want = 16'hBEEF;
`else
      want = 16'h0000;
`endif
      write_addr = 3'd3;
      write_data = 16'hBEEF;
      reg_write  = 1'b1;
      read1_addr = 3'd3;
      read2_addr = 3'd3;
      #1;
      vec++;
      if (read1_data !== want) begin
         err++;
         $display("FAIL same_cycle_rd1 got %h want %h", read1_data, want);
      end
      vec++;
      if (read2_data !== want) begin
         err++;
         $display("FAIL same_cycle_rd2 got %h want %h", read2_data, want);
      end
      tick();
      idle_inputs();
      #1;
      vec++;
      if (read1_data !== 16'hBEEF) begin
         err++;
         $display("FAIL next_cycle_rd1 got %h want beef", read1_data);
      end
   endtask

   task automatic test_pc_priority();
      incr_pc = 1'b1;
      tick();
      tick();
      tick();
      incr_pc = 1'b0;
      #1;
      vec++;
      if (pc_out !== 16'd3) begin
         err++;
         $display("FAIL pc_incr3 got %h want 0003", pc_out);
      end
      reg_write  = 1'b1;
      write_addr = 3'd7;
      write_data = 16'h0100;
      incr_pc    = 1'b1;
      tick();
      idle_inputs();
      #1;
      vec++;
      if (pc_out !== 16'h0100) begin
         err++;
         $display("FAIL pc_load_wins got %h want 0100", pc_out);
      end
      reg_write  = 1'b1;
      write_addr = 3'd7;
      write_data = 16'hFFFF;
      tick();
      idle_inputs();
      incr_pc = 1'b1;
      tick();
      idle_inputs();
      read1_addr = 3'd7;
      #1;
      vec++;
      if (pc_out !== 16'h0000) begin
         err++;
         $display("FAIL pc_wrap got %h want 0000", pc_out);
      end
      vec++;
      if (read1_data !== 16'h0000) begin
         err++;
         $display("FAIL pc_wrap_rd got %h want 0000", read1_data);
      end
   endtask

   task automatic fill_bank();
      for (int i = 0; i < 7; i++) begin
         reg_write  = 1'b1;
         write_addr = 3'(i);
         write_data = 16'h1111 * 16'(i + 1);
         tick();
      end
      write_addr = 3'd7;
      write_data = 16'h0042;
      tick();
      idle_inputs();
   endtask

   task automatic test_clear_walk();
      int n = 0;
      fill_bank();
      read1_addr = 3'd4;
      #1;
      vec++;
      if (read1_data !== 16'h5555) begin
         err++;
         $display("FAIL fill_r4 got %h want 5555", read1_data);
      end
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int c = 0; c < 12; c++) begin
         read1_addr = 3'(c % 8);
         read2_addr = 3'd2;
         reg_write  = (c == 5);
         write_addr = 3'd2;
         write_data = 16'hAAAA;
         #1;
         if (busy === 1'b1) n++;
         vec++;
         if (busy !== exp_busy()) begin
            err++;
            $display("FAIL walk_busy[%0d] got %b want %b", c, busy, exp_busy());
         end
         vec++;
         if (read1_data !== exp_rd(read1_addr)) begin
            err++;
            $display("FAIL walk_rd1[%0d] got %h want %h",
                     c, read1_data, exp_rd(read1_addr));
         end
         tick();
      end
      idle_inputs();
      vec++;
      if (n != 8) begin
         err++;
         $display("FAIL walk_len got %0d want 8", n);
      end
      for (int i = 0; i < 8; i++) begin
         read1_addr = 3'(i);
         #1;
         vec++;
         if (read1_data !== 16'h0000) begin
            err++;
            $display("FAIL walk_clr[%0d] got %h want 0000", i, read1_data);
         end
      end
      vec++;
      if (pc_out !== 16'h0000) begin
         err++;
         $display("FAIL walk_pc got %h want 0000", pc_out);
      end
   endtask

   task automatic test_reset_mid_walk();
      fill_bank();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      tick();
      tick();
      #1;
      vec++;
      if (busy !== 1'b1) begin
         err++;
         $display("FAIL midwalk_busy3 got %b want 1", busy);
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      #1;
      vec++;
      if (busy !== 1'b0) begin
         err++;
         $display("FAIL midwalk_rst_busy got %b want 0", busy);
      end
      for (int i = 0; i < 8; i++) begin
         read2_addr = 3'(i);
         #1;
         vec++;
         if (read2_data !== 16'h0000) begin
            err++;
            $display("FAIL midwalk_rst[%0d] got %h want 0000", i, read2_data);
         end
      end
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      #1;
      vec++;
      if (busy !== 1'b1) begin
         err++;
         $display("FAIL fresh_clear got %b want 1", busy);
      end
      for (int c = 0; c < 8; c++) tick();
      vec++;
      if (busy !== 1'b0) begin
         err++;
         $display("FAIL fresh_clear_end got %b want 0", busy);
      end
   endtask

   task automatic test_clear_retrigger();
      int n = 0;
      fill_bank();
      clear_req = 1'b1;
      tick();
      for (int c = 0; c < 12; c++) begin
         clear_req = (c < 4);
         #1;
         if (busy === 1'b1) n++;
         tick();
      end
      idle_inputs();
      vec++;
      if (n != 8) begin
         err++;
         $display("FAIL retrigger_len got %0d want 8", n);
      end
      vec++;
      if (busy !== 1'b0) begin
         err++;
         $display("FAIL retrigger_end got %b want 0", busy);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         reset_n    = ($urandom_range(0, 79) != 0);
         clear_req  = ($urandom_range(0, 39) == 0);
         reg_write  = $urandom_range(0, 1) == 1;
         incr_pc    = $urandom_range(0, 2) == 0;
         write_addr = 3'($urandom_range(0, 7));
         write_data = ($urandom_range(0, 9) == 0) ? 16'hFFFF
                                                  : 16'($urandom);
         read1_addr = 3'($urandom_range(0, 7));
         read2_addr = ($urandom_range(0, 3) == 0) ? write_addr
                                                  : 3'($urandom_range(0, 7));
         #1;
         vec++;
         if (read1_data !== exp_rd(read1_addr)) begin
            err++;
            $display("FAIL rand_rd1[%0d] got %h want %h",
                     c, read1_data, exp_rd(read1_addr));
         end
         vec++;
         if (read2_data !== exp_rd(read2_addr)) begin
            err++;
            $display("FAIL rand_rd2[%0d] got %h want %h",
                     c, read2_data, exp_rd(read2_addr));
         end
         vec++;
         if (pc_out !== m[7]) begin
            err++;
            $display("FAIL rand_pc[%0d] got %h want %h", c, pc_out, m[7]);
         end
         vec++;
         if (busy !== exp_busy()) begin
            err++;
            $display("FAIL rand_busy[%0d] got %b want %b",
                     c, busy, exp_busy());
         end
         tick();
      end
      reset_n = 1'b1;
      idle_inputs();
   endtask

   initial begin
      reset_n    = 1'b0;
      read1_addr = 3'd0;
      read2_addr = 3'd0;
      idle_inputs();
      for (int i = 0; i < 8; i++) m[i] = 16'h0000;
      @(negedge clock);
      test_reset();
      test_same_cycle_write();
      test_pc_priority();
      test_clear_walk();
      test_reset_mid_walk();
      test_clear_retrigger();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
